// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the four-way round-robin mux-select arbiter.
// Holds the requester count, the select width, the FSM state type and a one-hot decode.
package mux_arb_pkg;

   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
      logic [NUM_REQ-1:0] vec;
      vec      = '0;
      vec[idx] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: the search starts one past the last owner.
// It rotates the request vector, applies a fixed priority, then rotates the result back.
module rr_pick4
   import mux_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   last,
   output logic [SEL_W-1:0]   pick,
   output logic               any
);

   logic [SEL_W-1:0]   start;
   logic [NUM_REQ-1:0] rotated;
   logic [SEL_W-1:0]   offset;

   assign start = last + SEL_W'(1);
   assign any   = |req;

   // After rotation, bit 0 is the requester that has the highest priority this round.
   always_comb begin
      rotated = '0;
      offset  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rotated[i] = req[start + SEL_W'(i)];
      end
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rotated[i]) begin
            offset = SEL_W'(i);
         end
      end
      pick = start + offset;
   end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin owner of a shared 4:1 mux select, with a bounded burst length and a forced
// idle gap between owners. All outputs are registered, so the mux sees glitch-free controls.
module mux_sel_arbiter
   import mux_arb_pkg::*;
#(
   parameter int MAX_BURST = 16
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic [SEL_W-1:0]   sel,
   output logic               valid,
   output logic               preempt
);

   localparam int               CNT_W   = $clog2(MAX_BURST);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

   arb_state_t         state;
   arb_state_t         state_next;
   logic [NUM_REQ-1:0] grant_next;
   logic [SEL_W-1:0]   sel_next;
   logic [SEL_W-1:0]   last;
   logic [SEL_W-1:0]   last_next;
   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   count_next;
   logic               preempt_next;
   logic [SEL_W-1:0]   pick;
   logic               any_req;
   logic               others_waiting;

   rr_pick4 u_pick (
      .req  (req),
      .last (last),
      .pick (pick),
      .any  (any_req)
   );

   // While a grant is held, the owner is always the last pointer.
   assign others_waiting = (req & ~onehot4(last)) != '0;
   assign valid          = |grant;

   // The last pointer resets to 3, so requester 0 wins the first arbitration.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         grant   <= '0;
         sel     <= '0;
         last    <= SEL_W'(NUM_REQ - 1);
         count   <= '0;
         preempt <= 1'b0;
      end else begin
         state   <= state_next;
         grant   <= grant_next;
         sel     <= sel_next;
         last    <= last_next;
         count   <= count_next;
         preempt <= preempt_next;
      end
   end

   // Every exit from GRANT goes through IDLE, which produces the mandatory dead cycle.
   always_comb begin
      state_next   = state;
      grant_next   = grant;
      sel_next     = sel;
      last_next    = last;
      count_next   = count;
      preempt_next = 1'b0;
      case (state)
         IDLE: begin
            grant_next = '0;
            if (enable && any_req) begin
               state_next = GRANT;
               grant_next = onehot4(pick);
               sel_next   = pick;
               last_next  = pick;
               count_next = '0;
            end
         end
         GRANT: begin
            if (!req[last]) begin
               state_next = IDLE;
               grant_next = '0;
            end else if ((count == CNT_MAX) && others_waiting) begin
               state_next   = IDLE;
               grant_next   = '0;
               preempt_next = 1'b1;
            end else if (count != CNT_MAX) begin
               count_next = count + CNT_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
            grant_next = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed self-checking bench for mux_sel_arbiter with MAX_BURST = 4.
// It uses a table of round-robin vectors plus hand-written multi-cycle sequences.
module tb_mux_sel_arbiter;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic [3:0] req;
   logic [3:0] grant;
   logic [1:0] sel;
   logic       valid;
   logic       preempt;

   int vec_count  = 0;
   int miss_count = 0;

   typedef struct {
      logic       en;
      logic [3:0] req;
      logic [3:0] exp_grant;
      logic [1:0] exp_sel;
      logic       exp_pre;
   } vec_t;

   vec_t rr_table [21];

   mux_sel_arbiter #(.MAX_BURST(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (enable),
      .req     (req),
      .grant   (grant),
      .sel     (sel),
      .valid   (valid),
      .preempt (preempt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [3:0] exp_grant,
                               input logic [1:0] exp_sel, input logic exp_pre);
      logic exp_valid;
      exp_valid = (exp_grant != 4'b0000);
      vec_count++;
      if (grant !== exp_grant || sel !== exp_sel || valid !== exp_valid || preempt !== exp_pre) begin
         miss_count++;
         $display("[TB] FAIL %s: got grant=%b sel=%b valid=%b preempt=%b, need grant=%b sel=%b valid=%b preempt=%b",
                  name, grant, sel, valid, preempt, exp_grant, exp_sel, exp_valid, exp_pre);
      end
   endtask

   // Advance one clock and sample 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic en, input logic [3:0] r);
      enable = en;
      req    = r;
   endtask

   task automatic do_reset();
      req    = 4'b0000;
      enable = 1'b0;
      rst_n  = 1'b0;
      #2;
      check_output("reset_state", 4'b0000, 2'b00, 1'b0);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n  = 1'b0;
      enable = 1'b0;
      req    = 4'b0000;

      // All four requesters held: four grant cycles each, then a preempt gap.
      for (int k = 0; k < 21; k++) begin
         int pos;
         int owner;
         pos   = k % 5;
         owner = (k / 5) % 4;
         rr_table[k].en        = 1'b1;
         rr_table[k].req       = 4'b1111;
         rr_table[k].exp_grant = (pos < 4) ? (4'b0001 << owner) : 4'b0000;
         rr_table[k].exp_sel   = 2'(owner);
         rr_table[k].exp_pre   = (pos == 4);
      end

      #12;
      check_output("reset_state", 4'b0000, 2'b00, 1'b0);
      rst_n = 1'b1;

      foreach (rr_table[k]) begin
         apply_stimulus(rr_table[k].en, rr_table[k].req);
         step();
         check_output($sformatf("rr_vec%0d", k), rr_table[k].exp_grant,
                      rr_table[k].exp_sel, rr_table[k].exp_pre);
      end

      // Sole requester keeps its grant; a newcomer preempts it immediately.
      do_reset();
      apply_stimulus(1'b1, 4'b0100);
      for (int i = 0; i < 50; i++) begin
         step();
         check_output("solo_hold", 4'b0100, 2'b10, 1'b0);
      end
      apply_stimulus(1'b1, 4'b0101);
      step();
      check_output("solo_preempt", 4'b0000, 2'b10, 1'b1);
      step();
      check_output("solo_next", 4'b0001, 2'b00, 1'b0);

      // Voluntary release: the gap has no preempt, and sel holds the old owner.
      do_reset();
      apply_stimulus(1'b1, 4'b1010);
      step();
      check_output("rel_grant1", 4'b0010, 2'b01, 1'b0);
      step();
      check_output("rel_grant2", 4'b0010, 2'b01, 1'b0);
      apply_stimulus(1'b1, 4'b1000);
      step();
      check_output("rel_gap", 4'b0000, 2'b01, 1'b0);
      step();
      check_output("rel_next", 4'b1000, 2'b11, 1'b0);

      // Enable low blocks new grants only.
      do_reset();
      apply_stimulus(1'b0, 4'b0010);
      for (int i = 0; i < 3; i++) begin
         step();
         check_output("en_low_idle", 4'b0000, 2'b00, 1'b0);
      end
      apply_stimulus(1'b1, 4'b0010);
      step();
      check_output("en_high_grant", 4'b0010, 2'b01, 1'b0);
      apply_stimulus(1'b0, 4'b0010);
      for (int i = 0; i < 3; i++) begin
         step();
         check_output("en_drop_hold", 4'b0010, 2'b01, 1'b0);
      end
      apply_stimulus(1'b0, 4'b0000);
      step();
      check_output("en_drop_release", 4'b0000, 2'b01, 1'b0);
      apply_stimulus(1'b0, 4'b0010);
      for (int i = 0; i < 3; i++) begin
         step();
         check_output("en_drop_no_regrant", 4'b0000, 2'b01, 1'b0);
      end

      // Asynchronous reset mid-burst, then restart with requester 0 first.
      do_reset();
      apply_stimulus(1'b1, 4'b0100);
      step();
      check_output("async_pre_grant", 4'b0100, 2'b10, 1'b0);
      step();
      check_output("async_pre_hold", 4'b0100, 2'b10, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("async_reset_drop", 4'b0000, 2'b00, 1'b0);
      apply_stimulus(1'b1, 4'b1111);
      rst_n = 1'b1;
      step();
      check_output("async_restart", 4'b0001, 2'b00, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

endmodule
